ysyx_22040632_irq_sched: RTL
============================

// Module: ysyx_22040632_irq_sched
// PURPOSE
//  Machine-mode interrupt scheduler between CLINT/external sources and the EX stage.
//  - Registers raw pending lines into an mip image.
//  - Gates them with mstatus.MIE and the mie bits, then picks one winner by fixed priority.
//  - Presents the winner to EX with a req/ack handshake and blocks nesting until mret.
//  - Returns a one-cycle ack to the CLINT when a timer trap is taken.
// PARAMETERS
//  XLEN         32  width of irq_cause_o and mip_o
//  SYNC_STAGES  2   flop depth of meip synchroniser (only used with macro set; legal 2..4)
// PORTS
//  clk              in   1     clock
//  rrst_n           in   1     reset, asynchronous, active-low
//  mstatus_mie_bit  in   1     global M-mode interrupt enable
//  mie_mtie_bit     in   1     timer enable
//  mie_msie_bit     in   1     software enable
//  mie_meie_bit     in   1     external enable
//  mtip_i           in   1     CLINT timer pending (level, mtime>=mtimecmp)
//  msip_i           in   1     CLINT software pending (level)
//  meip_i           in   1     external pending (level, may be asynchronous)
//  ex_can_take_i    in   1     EX at instruction boundary, not stalled
//  irq_ack_i        in   1     EX committed trap entry this cycle
//  mret_i           in   1     mret retired this cycle
//  irq_req_o        out  1     interrupt request to EX
//  irq_cause_o      out  XLEN  mcause value {1'b1,0..,code[3:0]}
//  mip_o            out  XLEN  mip image for CSR read: bit11 MEIP, bit7 MTIP, bit3 MSIP, others 0
//  clint_ack_o      out  1     one-cycle pulse: timer trap taken
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, mip image 0, latched code 0.
//    Reset mid-REQ or mid-TRAP aborts to IDLE immediately.
//  - mip image: registered copy of mtip_i/msip_i/meip_i, 1-cycle latency.
//  - en_pend = mip & {meie,mtie,msie} & mstatus_mie_bit.
//  - Priority: MEI (code 11) > MSI (code 3) > MTI (code 7).
//  - FSM IDLE:
//    - en_pend!=0 && ex_can_take_i -> REQ.
//    - Latch winner code at this edge.
//  - FSM REQ:
//    - irq_req_o=1; irq_cause_o=0x8000_0000|code, held stable.
//    - Code is not re-arbitrated if a higher source rises while in REQ.
//    - irq_ack_i -> TRAP; clint_ack_o=1 next cycle iff code==7.
//    - Else if latched source no longer in en_pend -> IDLE (withdraw); irq_req_o drops next cycle.
//    - ack and withdraw in the same cycle: ack wins.
//  - FSM TRAP:
//    - irq_req_o=0; new pending stays visible only in mip_o.
//    - mret_i -> IDLE.
//    - mret_i in IDLE or REQ is ignored.
//  - Latency: source rises at edge N -> mip_o at N+1 -> irq_req_o at N+2 (if enabled, can_take high).
//  - irq_ack_i outside REQ is ignored.
//  - clint_ack_o is never high more than 1 cycle per trap.
//  - irq_cause_o reads 0 outside REQ.
// CONFIGURATION
//  YSYX_22040632_IRQ_SYNC_EN
//  - Defined: meip_i passes through a SYNC_STAGES-flop synchroniser (reset 0) before the mip image.
//    meip latency to irq_req_o becomes SYNC_STAGES+2 cycles.
//  - Undefined: meip_i is treated as synchronous, same 2-cycle latency as mtip/msip.
// TESTING
//  1. Basic timer: MIE=1, mtie=1, can_take=1, mtip_i 0->1 at N
//     -> irq_req_o=1 at N+2, cause 0x80000007.
//     -> ack at N+3 -> clint_ack_o=1 at N+4 only.
//  2. Priority: mtip, msip, meip all rise together, all enabled
//     -> cause 0x8000000B.
//     -> after ack+mret -> cause 0x80000003, then 0x80000007.
//  3. Withdraw: in REQ, drop mtip_i with no ack
//     -> irq_req_o=0 two cycles later, FSM IDLE, clint_ack_o stays 0.
//  4. Simultaneous ack and MIE clear in REQ -> TRAP entered, clint_ack_o pulses for code 7.
//  5. No nesting: in TRAP raise meip_i
//     -> irq_req_o stays 0 and mip_o[11]=1.
//     -> mret_i -> req 0x8000000B next cycle.
//  6. Reset asserted mid-REQ -> all outputs 0 asynchronously; with SYNC_EN, meip req latency = 4 cycles.

Source files
------------

// File: rtl/ysyx_22040632_irq_sched.sv
// rtl/ysyx_22040632_irq_sched.sv - M-mode interrupt scheduler: mip image, priority pick, EX req/ack, CLINT ack
// Optional meip synchroniser is enabled by defining YSYX_22040632_IRQ_SYNC_EN.
module ysyx_22040632_irq_sched #(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rrst_n,
  input  logic            mstatus_mie_bit,
  input  logic            mie_mtie_bit,
  input  logic            mie_msie_bit,
  input  logic            mie_meie_bit,
  input  logic            mtip_i,
  input  logic            msip_i,
  input  logic            meip_i,
  input  logic            ex_can_take_i,
  input  logic            irq_ack_i,
  input  logic            mret_i,
  output logic            irq_req_o,
  output logic [XLEN-1:0] irq_cause_o,
  output logic [XLEN-1:0] mip_o,
  output logic            clint_ack_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    TRAP = 2'd2
  } state_e;

  localparam logic [3:0] CODE_MSI = 4'd3;
  localparam logic [3:0] CODE_MTI = 4'd7;
  localparam logic [3:0] CODE_MEI = 4'd11;

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("SYNC_STAGES must be in 2..4");
    end
  endgenerate

  state_e     state_q, state_d;
  logic [3:0] code_q, code_d;
  logic       clint_ack_q, clint_ack_d;
  logic       mtip_q, msip_q, meip_q;
  logic       meip_src;

`ifdef YSYX_22040632_IRQ_SYNC_EN
  logic [SYNC_STAGES-1:0] meip_sync_q;

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      meip_sync_q <= '0;
    end else begin
      meip_sync_q <= {meip_sync_q[SYNC_STAGES-2:0], meip_i};
    end
  end

  assign meip_src = meip_sync_q[SYNC_STAGES-1];
`else
  assign meip_src = meip_i;
`endif

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      mtip_q <= 1'b0;
      msip_q <= 1'b0;
      meip_q <= 1'b0;
    end else begin
      mtip_q <= mtip_i;
      msip_q <= msip_i;
      meip_q <= meip_src;
    end
  end

  logic en_mei, en_msi, en_mti, any_pend, latched_live;
  logic [3:0] win_code;

  assign en_mei   = meip_q & mie_meie_bit & mstatus_mie_bit;
  assign en_msi   = msip_q & mie_msie_bit & mstatus_mie_bit;
  assign en_mti   = mtip_q & mie_mtie_bit & mstatus_mie_bit;
  assign any_pend = en_mei | en_msi | en_mti;

  always_comb begin
    win_code = CODE_MTI;
    if (en_mei) begin
      win_code = CODE_MEI;
    end else if (en_msi) begin
      win_code = CODE_MSI;
    end
  end

  // The request is withdrawn only when the source that won is gone, not any source.
  always_comb begin
    latched_live = 1'b0;
    case (code_q)
      CODE_MEI: latched_live = en_mei;
      CODE_MSI: latched_live = en_msi;
      CODE_MTI: latched_live = en_mti;
      default:  latched_live = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    clint_ack_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_pend && ex_can_take_i) begin
          state_d = REQ;
          code_d  = win_code;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          state_d     = TRAP;
          clint_ack_d = (code_q == CODE_MTI);
        end else if (!latched_live) begin
          state_d = IDLE;
        end
      end
      TRAP: begin
        if (mret_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q     <= IDLE;
      code_q      <= 4'd0;
      clint_ack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      clint_ack_q <= clint_ack_d;
    end
  end

  assign irq_req_o   = (state_q == REQ);
  assign irq_cause_o = irq_req_o ? {1'b1, {(XLEN-5){1'b0}}, code_q} : '0;
  assign clint_ack_o = clint_ack_q;

  always_comb begin
    mip_o     = '0;
    mip_o[11] = meip_q;
    mip_o[7]  = mtip_q;
    mip_o[3]  = msip_q;
  end

endmodule
